reloj_ctrl: RTL and testbench

//  Mode controller and sequencer for the alarm clock's BCD time counter. Debounces the

---
 rtl/reloj_ctrl_if.sv | 47 ++++
 rtl/reloj_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_reloj_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reloj_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : reloj_ctrl_if                                                  |
// | Purpose   : Bundles the alarm-clock controller's board/counter signals.    |
// |   tick_1s                   1 s pulse from the divider                     |
// |   b_mode, b_h, b_m, b_snz   raw buttons (active high, asynchronous)        |
// |   t_h1, t_h0, t_m1, t_m0    running time, BCD                              |
// |   inc_min, inc_hour         one-cycle advance strobes to the counter       |
// |   set_time                  inhibits the counter's minute->hour carry      |
// |   a_h1, a_h0, a_m1, a_m0    alarm time, BCD                                |
// |   mode                      00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 RING     |
// |   al_en, buzz               alarm armed / buzzer drive                     |
// | Modports  : slave = controller side, master = board/counter side          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface reloj_ctrl_if;
  logic       tick_1s;
  logic       b_mode;
  logic       b_h;
  logic       b_m;
  logic       b_snz;
  logic [3:0] t_h1;
  logic [3:0] t_h0;
  logic [3:0] t_m1;
  logic [3:0] t_m0;
  logic       inc_min;
  logic       inc_hour;
  logic       set_time;
  logic [3:0] a_h1;
  logic [3:0] a_h0;
  logic [3:0] a_m1;
  logic [3:0] a_m0;
  logic [1:0] mode;
  logic       al_en;
  logic       buzz;

  modport slave (
    input  tick_1s, b_mode, b_h, b_m, b_snz, t_h1, t_h0, t_m1, t_m0,
    output inc_min, inc_hour, set_time, a_h1, a_h0, a_m1, a_m0, mode, al_en, buzz
  );

  modport master (
    output tick_1s, b_mode, b_h, b_m, b_snz, t_h1, t_h0, t_m1, t_m0,
    input  inc_min, inc_hour, set_time, a_h1, a_h0, a_m1, a_m0, mode, al_en, buzz
  );
endinterface
`default_nettype wire

// File: rtl/reloj_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : reloj_ctrl                                                     |
// | Purpose   : Mode controller / sequencer for the alarm clock. Debounces the |
// |             four buttons, produces minute/hour advance strobes, holds the  |
// |             alarm time, compares it with the running time and drives the   |
// |             buzzer.                                                        |
// | Ports     : clk   - system clock (rising edge)                             |
// |             rst_n - asynchronous active-low reset                          |
// |             bus   - reloj_ctrl_if.slave (buttons, tick, time in; strobes,  |
// |                     alarm time, mode, al_en, buzz out)                     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module reloj_ctrl #(
  parameter logic [15:0] DEB_CYCLES  = 16'd50000,
  parameter logic [5:0]  SEC_PER_MIN = 6'd60,
  parameter logic [3:0]  RING_MIN    = 4'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  reloj_ctrl_if.slave bus
);

  localparam logic [1:0] c_ST_RUN       = 2'b00;
  localparam logic [1:0] c_ST_SET_TIME  = 2'b01;
  localparam logic [1:0] c_ST_SET_ALARM = 2'b10;
  localparam logic [1:0] c_ST_RING      = 2'b11;

  // Button index: 0 mode, 1 hour, 2 minute, 3 snooze
  logic [3:0] w_raw;
  logic [3:0] w_press;
  assign w_raw = {bus.b_snz, bus.b_m, bus.b_h, bus.b_mode};

  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic        r_s1;
    logic        r_s2;
    logic [1:0]  r_vld;   // marks the synchroniser as refilled after reset
    logic        r_arm;   // set once a genuine low has been observed
    logic        r_press;
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_vld   <= 2'b00;
        r_arm   <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= 16'd0;
      end else begin
        r_s1  <= w_raw[g];
        r_s2  <= r_s1;
        r_vld <= {r_vld[0], 1'b1};
        // The reset value of r_s2 is not a real observation, so a button
        // held through reset only arms once a real low comes through.
        if (!r_s2) begin
          r_cnt <= 16'd0;
          if (r_vld[1]) r_arm <= 1'b1;
        end else if (r_arm && (r_cnt != DEB_CYCLES)) begin
          r_cnt <= r_cnt + 16'd1;
        end
        // Counter saturates at DEB_CYCLES, so this fires once per high period.
        r_press <= r_arm && r_s2 && (r_cnt == DEB_CYCLES - 16'd1);
      end
    end

    assign w_press[g] = r_press;
  end

  // Priority mode > snz > h > m
  logic w_sel_mode, w_sel_snz, w_sel_h, w_sel_m, w_any;
  assign w_sel_mode = w_press[0];
  assign w_sel_snz  = w_press[3] & ~w_press[0];
  assign w_sel_h    = w_press[1] & ~w_press[0] & ~w_press[3];
  assign w_sel_m    = w_press[2] & ~w_press[0] & ~w_press[3] & ~w_press[1];
  assign w_any      = |w_press;

  logic [1:0] r_state, w_state_nxt;
  logic [5:0] r_sec;
  logic [3:0] r_ring_cnt;
  logic       r_tick_str, r_chk, r_inc_min, r_inc_hour, r_al_en;
  logic [3:0] r_a_h1, r_a_h0, r_a_m1, r_a_m0;

  logic w_set_time, w_buzz, w_sec_run, w_inc_min_p, w_inc_hour_p;
  logic w_am_inc, w_ah_inc, w_al_tog, w_wrap, w_match, w_ring_done;

  // r_chk marks the cycle after a tick strobe issued in RUN with the alarm
  // armed; the counter has applied the increment by then.
  assign w_match     = r_chk && ({bus.t_h1, bus.t_h0, bus.t_m1, bus.t_m0} ==
                                 {r_a_h1, r_a_h0, r_a_m1, r_a_m0});
  assign w_ring_done = r_tick_str && (r_ring_cnt == RING_MIN - 4'd1);
  assign w_wrap      = bus.tick_1s && w_sec_run && (r_sec == SEC_PER_MIN - 6'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (w_sel_mode)   w_state_nxt = c_ST_SET_TIME;
        else if (w_match) w_state_nxt = c_ST_RING;
      end
      c_ST_SET_TIME:  if (w_sel_mode) w_state_nxt = c_ST_SET_ALARM;
      c_ST_SET_ALARM: if (w_sel_mode) w_state_nxt = c_ST_RUN;
      default:        if (w_any || w_ring_done) w_state_nxt = c_ST_RUN;
    endcase
  end

  // State-decoded actions
  always_comb begin
    w_set_time   = 1'b0;
    w_buzz       = 1'b0;
    w_sec_run    = 1'b1;
    w_inc_min_p  = 1'b0;
    w_inc_hour_p = 1'b0;
    w_am_inc     = 1'b0;
    w_ah_inc     = 1'b0;
    w_al_tog     = 1'b0;
    case (r_state)
      c_ST_SET_TIME: begin
        w_set_time   = 1'b1;
        w_sec_run    = 1'b0;
        w_inc_min_p  = w_sel_m;
        w_inc_hour_p = w_sel_h;
      end
      c_ST_SET_ALARM: begin
        w_am_inc = w_sel_m;
        w_ah_inc = w_sel_h;
      end
      c_ST_RING: w_buzz = 1'b1;
      default:   w_al_tog = w_sel_snz;
    endcase
  end

  // Datapath: seconds, strobes, ring timer, alarm registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec      <= 6'd0;
      r_tick_str <= 1'b0;
      r_chk      <= 1'b0;
      r_inc_min  <= 1'b0;
      r_inc_hour <= 1'b0;
      r_ring_cnt <= 4'd0;
      r_al_en    <= 1'b0;
      r_a_h1     <= 4'd0;
      r_a_h0     <= 4'd0;
      r_a_m1     <= 4'd0;
      r_a_m0     <= 4'd0;
    end else begin
      if (!w_sec_run)       r_sec <= 6'd0;
      else if (w_wrap)      r_sec <= 6'd0;
      else if (bus.tick_1s) r_sec <= r_sec + 6'd1;

      r_tick_str <= w_wrap;
      r_inc_min  <= w_wrap | w_inc_min_p;
      r_inc_hour <= w_inc_hour_p;
      r_chk      <= r_tick_str && (r_state == c_ST_RUN) && r_al_en;

      if (r_state != c_ST_RING) r_ring_cnt <= 4'd0;
      else if (r_tick_str)      r_ring_cnt <= r_ring_cnt + 4'd1;

      if (w_al_tog) r_al_en <= ~r_al_en;

      if (w_am_inc) begin
        if (r_a_m0 == 4'd9) begin
          r_a_m0 <= 4'd0;
          r_a_m1 <= (r_a_m1 == 4'd5) ? 4'd0 : r_a_m1 + 4'd1;
        end else begin
          r_a_m0 <= r_a_m0 + 4'd1;
        end
      end

      if (w_ah_inc) begin
        if (r_a_h1 == 4'd2 && r_a_h0 == 4'd3) begin
          r_a_h1 <= 4'd0;
          r_a_h0 <= 4'd0;
        end else if (r_a_h0 == 4'd9) begin
          r_a_h0 <= 4'd0;
          r_a_h1 <= r_a_h1 + 4'd1;
        end else begin
          r_a_h0 <= r_a_h0 + 4'd1;
        end
      end
    end
  end

  assign bus.inc_min  = r_inc_min;
  assign bus.inc_hour = r_inc_hour;
  assign bus.set_time = w_set_time;
  assign bus.buzz     = w_buzz;
  assign bus.mode     = r_state;
  assign bus.al_en    = r_al_en;
  assign bus.a_h1     = r_a_h1;
  assign bus.a_h0     = r_a_h0;
  assign bus.a_m1     = r_a_m1;
  assign bus.a_m0     = r_a_m0;

endmodule
`default_nettype wire

// File: tb/tb_reloj_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_reloj_ctrl                                                  |
// | Purpose   : Self-checking bench for reloj_ctrl (DEB_CYCLES=4,              |
// |             SEC_PER_MIN=4, RING_MIN=2). Expected strobe / mode-change      |
// |             events are queued with their cycle when stimulus is driven.   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_reloj_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct packed {
    int         cyc;
    logic [1:0] kind;  // strobes: 01 inc_min, 10 inc_hour; mode events: new mode
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;

  reloj_ctrl_if bus();

  reloj_ctrl #(
    .DEB_CYCLES (16'd4),
    .SEC_PER_MIN(6'd4),
    .RING_MIN   (4'd2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       bus.b_mode = v;
      1:       bus.b_h    = v;
      2:       bus.b_m    = v;
      default: bus.b_snz  = v;
    endcase
  endtask

  // Clean press: high for 8 samples, then low for 4.
  task automatic press(input int idx);
    @(negedge clk);
    set_btn(idx, 1'b1);
    repeat (8) @(negedge clk);
    set_btn(idx, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic set_t(input logic [3:0] h1, h0, m1, m0);
    bus.t_h1 = h1; bus.t_h0 = h0; bus.t_m1 = m1; bus.t_m0 = m0;
  endtask

  task automatic next_min();
    if (bus.t_m0 == 4'd9) begin
      bus.t_m0 = 4'd0;
      bus.t_m1 = bus.t_m1 + 4'd1;
    end else begin
      bus.t_m0 = bus.t_m0 + 4'd1;
    end
  endtask

  task automatic test_reset();
    bus.tick_1s = 1'b0; bus.b_h = 1'b0; bus.b_m = 1'b0; bus.b_snz = 1'b0;
    bus.b_mode = 1'b1;  // held through reset release
    set_t(4'd0, 4'd0, 4'd0, 4'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.mode !== 2'b00) begin
      n_fail++; $display("FAIL reset_mode: got %b expected 00", bus.mode);
    end
    n_chk++;
    if ({bus.inc_min, bus.inc_hour, bus.set_time, bus.buzz, bus.al_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 00000",
               {bus.inc_min, bus.inc_hour, bus.set_time, bus.buzz, bus.al_en});
    end
    n_chk++;
    if ({bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_alarm: got %h expected 0000", {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0});
    end
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    n_chk++;
    if (bus.mode !== 2'b00) begin
      n_fail++; $display("FAIL held_through_reset: mode got %b expected 00", bus.mode);
    end
    bus.b_mode = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_bounce();
    int strobes = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.inc_min || bus.inc_hour) strobes++;
      bus.b_m = (i < 3) || (i >= 4 && i < 14);
    end
    n_chk++;
    if (strobes != 0) begin
      n_fail++; $display("FAIL bounce_strobes: got %0d expected 0", strobes);
    end
    n_chk++;
    if (bus.mode !== 2'b00) begin
      n_fail++; $display("FAIL bounce_mode: got %b expected 00", bus.mode);
    end
  endtask

  task automatic test_ticks();
    int nt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.inc_min || bus.inc_hour) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL tick_extra_strobe: got strobe at cycle %0d expected none", cyc);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.kind !== {bus.inc_hour, bus.inc_min}) begin
            n_fail++;
            $display("FAIL tick_strobe: got cyc %0d kind %b expected cyc %0d kind %b",
                     cyc, {bus.inc_hour, bus.inc_min}, ev.cyc, ev.kind);
          end
        end
      end
      bus.tick_1s = (i % 3 == 0) && (i < 24);
      if (bus.tick_1s) begin
        if (nt % 4 == 3) begin ev.cyc = cyc + 1; ev.kind = 2'b01; exp_q.push_back(ev); end
        nt++;
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL tick_missing: got %0d strobes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_set_time();
    press(0);
    n_chk++;
    if (bus.mode !== 2'b01 || bus.set_time !== 1'b1) begin
      n_fail++; $display("FAIL enter_set_time: got mode %b set_time %b expected 01 1", bus.mode, bus.set_time);
    end
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.inc_min || bus.inc_hour) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL set_extra_strobe: got strobe at cycle %0d expected none", cyc);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.kind !== {bus.inc_hour, bus.inc_min}) begin
            n_fail++;
            $display("FAIL set_strobe: got cyc %0d kind %b expected cyc %0d kind %b",
                     cyc, {bus.inc_hour, bus.inc_min}, ev.cyc, ev.kind);
          end
        end
      end
      bus.b_h     = (i < 8) || (i >= 12 && i < 20);
      bus.b_m     = (i >= 24 && i < 32);
      bus.tick_1s = (i % 5 == 2);
      // 2 sync + 4 debounce cycles to the press pulse, one more for the strobe
      if (i == 0 || i == 12) begin ev.cyc = cyc + 7; ev.kind = 2'b10; exp_q.push_back(ev); end
      if (i == 24)           begin ev.cyc = cyc + 7; ev.kind = 2'b01; exp_q.push_back(ev); end
    end
    bus.tick_1s = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL set_missing: got %0d strobes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_set_alarm();
    press(0);
    n_chk++;
    if (bus.mode !== 2'b10 || bus.set_time !== 1'b0) begin
      n_fail++; $display("FAIL enter_set_alarm: got mode %b set_time %b expected 10 0", bus.mode, bus.set_time);
    end
    repeat (10) press(1);
    n_chk++;
    if ({bus.a_h1, bus.a_h0} !== 8'h10) begin
      n_fail++; $display("FAIL alarm_h_10: got %h expected 10", {bus.a_h1, bus.a_h0});
    end
    repeat (13) press(1);
    repeat (59) press(2);
    n_chk++;
    if ({bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} !== 16'h2359) begin
      n_fail++; $display("FAIL alarm_2359: got %h expected 2359", {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0});
    end
    press(2);
    n_chk++;
    if ({bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} !== 16'h2300) begin
      n_fail++; $display("FAIL alarm_min_wrap: got %h expected 2300", {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0});
    end
    press(1);
    n_chk++;
    if ({bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} !== 16'h0000) begin
      n_fail++; $display("FAIL alarm_hour_wrap: got %h expected 0000", {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0});
    end
    repeat (7) press(1);
    repeat (30) press(2);
    n_chk++;
    if ({bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} !== 16'h0730) begin
      n_fail++; $display("FAIL alarm_0730: got %h expected 0730", {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0});
    end
    press(0);
    n_chk++;
    if (bus.mode !== 2'b00) begin
      n_fail++; $display("FAIL back_to_run: got %b expected 00", bus.mode);
    end
  endtask

  // Ticks until the alarm fires; ring_end_strobe>0 also queues the auto stop.
  task automatic run_to_ring(input string name, input int ring_end_strobe, input int n_cyc);
    int         ns = 0;
    logic [1:0] pm;
    pm = bus.mode;
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      if (bus.inc_min) begin
        ns++;
        next_min();
        if (ns == 1) begin ev.cyc = cyc + 2; ev.kind = 2'b11; exp_q.push_back(ev); end
        if (ns == ring_end_strobe) begin ev.cyc = cyc + 1; ev.kind = 2'b00; exp_q.push_back(ev); end
      end
      if (bus.mode !== pm) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s_mode_event: got mode %b at cycle %0d expected no change", name, bus.mode, cyc);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.kind !== bus.mode) begin
            n_fail++;
            $display("FAIL %s_mode_event: got mode %b cyc %0d expected mode %b cyc %0d",
                     name, bus.mode, cyc, ev.kind, ev.cyc);
          end
        end
      end
      pm = bus.mode;
      bus.tick_1s = (i % 3 == 0) && (ns < ((ring_end_strobe > 0) ? ring_end_strobe : 1));
    end
    bus.tick_1s = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_missing_event: got %0d outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_alarm_snooze();
    press(3);
    n_chk++;
    if (bus.al_en !== 1'b1 || bus.mode !== 2'b00) begin
      n_fail++; $display("FAIL arm: got al_en %b mode %b expected 1 00", bus.al_en, bus.mode);
    end
    set_t(4'd0, 4'd7, 4'd2, 4'd9);
    run_to_ring("alarm", 0, 24);
    n_chk++;
    if (bus.mode !== 2'b11 || bus.buzz !== 1'b1) begin
      n_fail++; $display("FAIL ring: got mode %b buzz %b expected 11 1", bus.mode, bus.buzz);
    end
    press(3);
    n_chk++;
    if (bus.mode !== 2'b00 || bus.buzz !== 1'b0 || bus.al_en !== 1'b1) begin
      n_fail++;
      $display("FAIL snooze_stop: got mode %b buzz %b al_en %b expected 00 0 1", bus.mode, bus.buzz, bus.al_en);
    end
  endtask

  task automatic test_ring_auto();
    set_t(4'd0, 4'd7, 4'd2, 4'd9);
    run_to_ring("auto", 3, 60);
    n_chk++;
    if (bus.buzz !== 1'b0 || bus.mode !== 2'b00 || bus.al_en !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_stop: got buzz %b mode %b al_en %b expected 0 00 1", bus.buzz, bus.mode, bus.al_en);
    end
  endtask

  task automatic test_ring_reset();
    set_t(4'd0, 4'd7, 4'd2, 4'd9);
    run_to_ring("rst", 0, 24);
    n_chk++;
    if (bus.buzz !== 1'b1) begin
      n_fail++; $display("FAIL ring_before_reset: got buzz %b expected 1", bus.buzz);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.mode, bus.buzz, bus.al_en, bus.set_time, bus.inc_min, bus.inc_hour} !== 7'b0 ||
        {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: got ctl %b alarm %h expected 0000000 0000",
               {bus.mode, bus.buzz, bus.al_en, bus.set_time, bus.inc_min, bus.inc_hour},
               {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0});
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_ticks();
    test_set_time();
    test_set_alarm();
    test_alarm_snooze();
    test_ring_auto();
    test_ring_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
